// File: rtl/fetch_decode.sv
// fetch_decode: instruction fetch and decode sequencer.
// It fetches one instruction word from instruction memory, optionally fetches
// a trailing constant word, and then presents the decoded fields to the datapath.
// Optional feature: define FETCH_DECODE_CONST_WORD_EN to enable two-word
// instructions (IR[0]=1 fetches a constant word from program_counter+1).
// Without it, IR[0] is ignored, constant reads 0 and const_c reads 0.
//
// Memory handshake: imem_req is high for the whole FETCH/FETCH_CONST state,
// and imem_addr is held stable while imem_req is high. A word is transferred
// on any rising edge where imem_req and imem_ack are both high. Because the
// state then changes, imem_req drops in the following cycle. imem_ack is
// ignored whenever imem_req is low.
// dbg_state exposes the FSM encoding (IDLE=0, FETCH=1, FETCH_CONST=2,
// ISSUE=3, INC=4).
module fetch_decode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [31:0] program_counter,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [2:0]  op,
  output logic        form,
  output logic [1:0]  vec,
  output logic [3:0]  alu_config,
  output logic [3:0]  A,
  output logic [3:0]  B,
  output logic [3:0]  C,
  output logic [3:0]  D,
  output logic [3:0]  Y1,
  output logic [3:0]  Y2,
  output logic [1:0]  write,
  output logic        const_c,
  output logic        pc_inc,
  output logic [31:0] constant,
  output logic [3:0]  copy_select,
  output logic        busy,
  output logic [2:0]  dbg_state
);

`ifdef FETCH_DECODE_CONST_WORD_EN
  localparam logic CONST_EN = 1'b1;
`else
  localparam logic CONST_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_FETCH       = 3'd1,
    S_FETCH_CONST = 3'd2,
    S_ISSUE       = 3'd3,
    S_INC         = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] ir_q;
  logic [3:0]  alu_config_q;
  logic [3:0]  copy_select_q;
  logic        ext;
  logic        is_config;

  // ext only has meaning when two-word instructions are enabled
  assign ext       = ir_q[0] & CONST_EN;
  assign is_config = (ir_q[31:29] == 3'b000) && ir_q[28];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; once fetch starts the instruction always completes
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:        if (run) state_d = S_FETCH;
      S_FETCH:       if (imem_ack) state_d = (imem_rdata[0] & CONST_EN) ? S_FETCH_CONST : S_ISSUE;
      S_FETCH_CONST: if (imem_ack) state_d = S_ISSUE;
      S_ISSUE:       state_d = ext ? S_INC : (run ? S_FETCH : S_IDLE);
      S_INC:         state_d = run ? S_FETCH : S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = 32'd0;
    write     = 2'b00;
    pc_inc    = 1'b0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = program_counter;
      end
      S_FETCH_CONST: begin
        imem_req  = 1'b1;
        imem_addr = program_counter + 32'd1;
      end
      S_ISSUE: begin
        pc_inc = 1'b1;
        if (ir_q[31:29] == 3'b000) write = 2'b00;
        else                       write = ir_q[28] ? 2'b11 : 2'b01;
      end
      S_INC:   pc_inc = 1'b1;
      default: ;
    endcase
  end

  // Instruction register, loaded on the instruction-word transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             ir_q <= 32'd0;
    else if (state_q == S_FETCH && imem_ack) ir_q <= imem_rdata;
  end

  // CONFIG instructions update the persistent ALU and copy settings
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_config_q  <= 4'd0;
      copy_select_q <= 4'd0;
    end else if (state_q == S_ISSUE && is_config) begin
      alu_config_q  <= ir_q[17:14];
      copy_select_q <= ir_q[13:10];
    end
  end

`ifdef FETCH_DECODE_CONST_WORD_EN
  logic [31:0] constant_q;

  // Constant register, loaded on the constant-word transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   constant_q <= 32'd0;
    else if (state_q == S_FETCH_CONST && imem_ack) constant_q <= imem_rdata;
  end

  assign constant = constant_q;
`else
  assign constant = 32'd0;
`endif

  assign op          = ir_q[31:29];
  assign form        = ir_q[28];
  assign vec         = ir_q[27:26];
  assign Y1          = ir_q[25:22];
  assign Y2          = ir_q[21:18];
  assign A           = ir_q[17:14];
  assign B           = ir_q[13:10];
  assign C           = ir_q[9:6];
  assign D           = ir_q[5:2];
  assign const_c     = ir_q[1] & CONST_EN;
  assign alu_config  = alu_config_q;
  assign copy_select = copy_select_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: directed bench for fetch_decode.
// Follows FETCH_DECODE_CONST_WORD_EN the same way as the design.
module tb_fetch_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [31:0] program_counter;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [2:0]  op;
  logic        form;
  logic [1:0]  vec;
  logic [3:0]  alu_config;
  logic [3:0]  A, B, C, D, Y1, Y2;
  logic [1:0]  write;
  logic        const_c;
  logic        pc_inc;
  logic [31:0] constant;
  logic [3:0]  copy_select;
  logic        busy;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  fetch_decode dut (
    .clk(clk), .rst_n(rst_n), .run(run), .program_counter(program_counter),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .op(op), .form(form), .vec(vec),
    .alu_config(alu_config), .A(A), .B(B), .C(C), .D(D), .Y1(Y1), .Y2(Y2),
    .write(write), .const_c(const_c), .pc_inc(pc_inc), .constant(constant),
    .copy_select(copy_select), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every transfer must match the next expected fetch address
  always @(negedge clk) begin
    if (rst_n && imem_req && imem_ack) begin
      check_eq("req_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check_eq("fetch_addr", imem_addr, exp_q.pop_front());
    end
  end

  // driver: serve one word after 'waits' idle cycles; ends in the next state
  task automatic do_fetch(input logic [31:0] word, input int waits, input logic [31:0] addr);
    exp_q.push_back(addr);
    for (int i = 0; i < waits; i++) begin
      check_eq("req_wait", 32'(imem_req), 32'd1);
      step();
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'hBAD0_BAD1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0;
    imem_rdata = 32'd0; program_counter = 32'd0;
    #1;
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);
    check_eq("rst_write", 32'(write), 32'd0);
    check_eq("rst_pc_inc", 32'(pc_inc), 32'd0);
    check_eq("rst_op", 32'(op), 32'd0);
    check_eq("rst_addr", imem_addr, 32'd0);
    check_eq("rst_const", constant, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    check_eq("idle_hold", 32'(busy), 32'd0);

    // single-word ALU instruction, zero-wait memory
    program_counter = 32'h10; run = 1'b1;
    step();
    check_eq("t1_req", 32'(imem_req), 32'd1);
    check_eq("t1_addr", imem_addr, 32'h10);
    check_eq("t1_busy", 32'(busy), 32'd1);
    check_eq("t1_fetch_pc_inc", 32'(pc_inc), 32'd0);
    do_fetch(32'h4A8C_4A14, 0, 32'h10);
    run = 1'b0;
    check_eq("t1_req_drop", 32'(imem_req), 32'd0);
    check_eq("t1_op", 32'(op), 32'd2);
    check_eq("t1_form", 32'(form), 32'd0);
    check_eq("t1_vec", 32'(vec), 32'd2);
    check_eq("t1_y1", 32'(Y1), 32'hA);
    check_eq("t1_y2", 32'(Y2), 32'h3);
    check_eq("t1_a", 32'(A), 32'h1);
    check_eq("t1_b", 32'(B), 32'h2);
    check_eq("t1_c", 32'(C), 32'h8);
    check_eq("t1_d", 32'(D), 32'h5);
    check_eq("t1_write", 32'(write), 32'd1);
    check_eq("t1_pc_inc", 32'(pc_inc), 32'd1);
    step();
    check_eq("t1_pc_inc_end", 32'(pc_inc), 32'd0);
    check_eq("t1_idle", 32'(busy), 32'd0);
    check_eq("t1_op_hold", 32'(op), 32'd2);

    // CONFIG then three more instructions back to back
    program_counter = 32'h20; run = 1'b1;
    step();
    do_fetch(32'h1001_6400, 1, 32'h20);
    check_eq("cfg_write", 32'(write), 32'd0);
    check_eq("cfg_pc_inc", 32'(pc_inc), 32'd1);
    check_eq("cfg_alu_before", 32'(alu_config), 32'd0);
    step();
    check_eq("cfg_alu", 32'(alu_config), 32'd5);
    check_eq("cfg_copy", 32'(copy_select), 32'd9);
    check_eq("cfg_refetch", 32'(imem_req), 32'd1);
    program_counter = 32'h21;
    do_fetch(32'h4A8C_4A14, 0, 32'h21);
    check_eq("i2_write", 32'(write), 32'd1);
    step();
    program_counter = 32'h22;
    do_fetch(32'h3000_0000, 2, 32'h22);
    check_eq("i3_write", 32'(write), 32'd3);
    check_eq("i3_alu", 32'(alu_config), 32'd5);
    step();
    program_counter = 32'h23;
    do_fetch(32'h0000_0000, 0, 32'h23);
    check_eq("i4_write", 32'(write), 32'd0);
    run = 1'b0;
    step();
    check_eq("i4_alu_hold", 32'(alu_config), 32'd5);
    check_eq("i4_copy_hold", 32'(copy_select), 32'd9);
    check_eq("i4_idle", 32'(busy), 32'd0);

    // run drops while waiting for memory: instruction still completes
    program_counter = 32'h30; run = 1'b1;
    step();
    run = 1'b0;
    do_fetch(32'h6000_0000, 2, 32'h30);
    check_eq("t3_write", 32'(write), 32'd1);
    check_eq("t3_pc_inc", 32'(pc_inc), 32'd1);
    step();
    check_eq("t3_idle", 32'(busy), 32'd0);

`ifdef FETCH_DECODE_CONST_WORD_EN
    // two-word instruction
    program_counter = 32'h40; run = 1'b1;
    step();
    do_fetch(32'h5000_0003, 0, 32'h40);
    check_eq("tw_req", 32'(imem_req), 32'd1);
    check_eq("tw_addr", imem_addr, 32'h41);
    check_eq("tw_pc_inc0", 32'(pc_inc), 32'd0);
    do_fetch(32'hDEAD_BEEF, 1, 32'h41);
    run = 1'b0;
    check_eq("tw_const", constant, 32'hDEAD_BEEF);
    check_eq("tw_const_c", 32'(const_c), 32'd1);
    check_eq("tw_pc_inc1", 32'(pc_inc), 32'd1);
    check_eq("tw_write", 32'(write), 32'd3);
    step();
    check_eq("tw_pc_inc2", 32'(pc_inc), 32'd1);
    check_eq("tw_inc_write", 32'(write), 32'd0);
    check_eq("tw_inc_busy", 32'(busy), 32'd1);
    step();
    check_eq("tw_pc_inc3", 32'(pc_inc), 32'd0);
    check_eq("tw_idle", 32'(busy), 32'd0);

    // constant fetch address wraps
    program_counter = 32'hFFFF_FFFF; run = 1'b1;
    step();
    check_eq("wrap_addr0", imem_addr, 32'hFFFF_FFFF);
    do_fetch(32'h5000_0001, 0, 32'hFFFF_FFFF);
    check_eq("wrap_addr1", imem_addr, 32'h0000_0000);
    do_fetch(32'h1234_5678, 0, 32'h0000_0000);
    run = 1'b0;
    check_eq("wrap_const", constant, 32'h1234_5678);
    check_eq("wrap_const_c", 32'(const_c), 32'd0);
    step();
    step();
    check_eq("wrap_idle", 32'(busy), 32'd0);
`else
    // IR[0] set but two-word support is off
    program_counter = 32'h40; run = 1'b1;
    step();
    do_fetch(32'h5000_0003, 0, 32'h40);
    run = 1'b0;
    check_eq("sw_req", 32'(imem_req), 32'd0);
    check_eq("sw_const_c", 32'(const_c), 32'd0);
    check_eq("sw_const", constant, 32'd0);
    check_eq("sw_pc_inc", 32'(pc_inc), 32'd1);
    check_eq("sw_write", 32'(write), 32'd3);
    step();
    check_eq("sw_pc_inc_end", 32'(pc_inc), 32'd0);
    check_eq("sw_idle", 32'(busy), 32'd0);

    program_counter = 32'hFFFF_FFFF; run = 1'b1;
    step();
    check_eq("sw_wrap_addr", imem_addr, 32'hFFFF_FFFF);
    do_fetch(32'h5000_0001, 0, 32'hFFFF_FFFF);
    run = 1'b0;
    check_eq("sw_wrap_state", 32'(dbg_state), 32'd3);
    step();
    check_eq("sw_wrap_idle", 32'(busy), 32'd0);
`endif

    // reset in the middle of a slow handshake
    program_counter = 32'h50; run = 1'b1;
    step();
    check_eq("rr_req", 32'(imem_req), 32'd1);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rr_req_drop", 32'(imem_req), 32'd0);
    check_eq("rr_busy", 32'(busy), 32'd0);
    check_eq("rr_addr", imem_addr, 32'd0);
    check_eq("rr_op", 32'(op), 32'd0);
    check_eq("rr_alu", 32'(alu_config), 32'd0);
    check_eq("rr_copy", 32'(copy_select), 32'd0);
    check_eq("rr_write", 32'(write), 32'd0);
    step();
    rst_n = 1'b1; run = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h7FFF_FFFF;
    step();
    check_eq("rr_late_ack_busy", 32'(busy), 32'd0);
    check_eq("rr_late_ack_op", 32'(op), 32'd0);
    imem_ack = 1'b0; run = 1'b1;
    step();
    check_eq("rr_restart_req", 32'(imem_req), 32'd1);
    check_eq("rr_restart_addr", imem_addr, 32'h50);
    do_fetch(32'h4A8C_4A14, 0, 32'h50);
    run = 1'b0;
    check_eq("rr_issue_op", 32'(op), 32'd2);
    step();
    check_eq("rr_final_idle", 32'(busy), 32'd0);

    check_eq("addr_q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_decode.md
FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: run  in  1  fetch enable; low holds FSM in IDLE.
REQ-004 SHALL have: program_counter  in  32  current PC from datapath register 0.
REQ-005 SHALL have: imem_req  out  1 / imem_addr  out  32 / imem_ack  in  1 / imem_rdata  in  32  (instruction memory read handshake).
REQ-006 SHALL have outputs to datapath: op 3, form 1, vec 2, alu_config 4, A/B/C/D 4 each, Y1/Y2 4 each, write 2, const_c 1, pc_inc 1, constant 32, copy_select 4.
REQ-007 SHALL have: busy  out  1  high in any state other than IDLE.

Function
REQ-008 SHALL implement states IDLE, FETCH, FETCH_CONST, ISSUE, INC.
REQ-009 IDLE -> FETCH when run=1; else stays IDLE.
REQ-010 FETCH: imem_req=1, imem_addr=program_counter; held stable until imem_ack=1.
REQ-011 On imem_ack in FETCH, imem_rdata SHALL be captured into IR same edge; next state FETCH_CONST if IR[0]=1, else ISSUE.
REQ-012 FETCH_CONST: imem_req=1, imem_addr=program_counter+1 (32-bit wrap); on ack capture rdata into constant register, go ISSUE.
REQ-013 imem_req SHALL drop in the cycle after ack; back-to-back requests only via a new FETCH/FETCH_CONST state.
REQ-014 IR decode: op=[31:29], form=[28], vec=[27:26], Y1=[25:22], Y2=[21:18], A=[17:14], B=[13:10], C=[9:6], D=[5:2], const_c=[1], ext=[0].
REQ-015 Field outputs SHALL be registered from IR and stable from ISSUE entry until next IR capture.
REQ-016 write SHALL be 2'b00 outside ISSUE; in ISSUE: op=000 -> 00; else form=0 -> 01, form=1 -> 11.
REQ-017 op=000 form=1 (CONFIG) SHALL load alu_config<=A and copy_select<=B at ISSUE edge; these hold until next CONFIG.
REQ-018 pc_inc SHALL be 1 exactly one cycle in ISSUE and one cycle in INC, 0 otherwise.
REQ-019 ISSUE -> INC if ext=1, else -> FETCH if run=1, else IDLE.
REQ-020 INC -> FETCH if run=1, else IDLE; net PC advance is 1 per single-word and 2 per two-word instruction.
REQ-021 run deasserting mid-instruction SHALL NOT abort; instruction completes through ISSUE/INC, then IDLE.
REQ-022 imem_ack outside FETCH/FETCH_CONST SHALL be ignored.
REQ-023 Minimum latency: single-word instruction with zero-wait memory = 2 cycles (FETCH, ISSUE); two-word = 4 cycles.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, imem_req=0, pc_inc=0, write=0, busy=0.
REQ-025 Reset SHALL clear IR, constant, alu_config, copy_select, imem_addr and all field outputs to 0.
REQ-026 Reset asserted mid-handshake SHALL abandon the request; a pending ack after release SHALL be ignored (FSM in IDLE).

Configuration
REQ-027 Macro FETCH_DECODE_CONST_WORD_EN defined: two-word instructions per REQ-011/012/019/020.
REQ-028 Macro undefined: IR[0] ignored, FETCH_CONST and INC unreachable, constant fixed 32'b0, const_c output forced 0.

Verification
REQ-029 run=1, pc=0x10, word 0x4A8C_4A14 acked in 1 cycle -> imem_addr=0x10, ISSUE next cycle with op=010 form=0 write=01 pc_inc=1 single cycle.
REQ-030 With macro: word with IR[0]=1, const word 0xDEAD_BEEF -> second request at pc+1, constant=0xDEADBEEF in ISSUE, pc_inc high in ISSUE and INC (2 total).
REQ-031 pc=0xFFFF_FFFF, two-word instruction -> const fetch address 0x0000_0000.
REQ-032 CONFIG word (op=000 form=1, A=5, B=9) -> write=00, alu_config=5, copy_select=9 persisting across next 3 instructions.
REQ-033 imem_ack delayed 3 cycles, rst_n pulsed low in 2nd wait cycle -> imem_req drops asynchronously, all outputs 0, late ack ignored, restart from FETCH after rst_n high with run=1.
REQ-034 Without macro: IR[0]=1 word -> single ISSUE, one pc_inc, const_c=0, constant=0.
